// File: rtl/sprite_blitter.sv
// Sprite blitter: queues draw commands, walks sprite pixels from a synchronous ROM,
// drops transparent/off-screen pixels and holds each kept pixel until a write slot.
module sprite_blitter #(
    parameter int          CMD_DEPTH   = 8,
    parameter int          ROM_AW      = 14,
    parameter logic [15:0] TRANSPARENT = 16'h0000,
    parameter int          H_RES       = 640,
    parameter int          V_RES       = 480
) (
    input  logic              sram_clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [9:0]        cmd_y,
    input  logic [5:0]        cmd_w,
    input  logic [5:0]        cmd_h,
    input  logic [ROM_AW-1:0] cmd_base,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic              write_strobe,
    output logic [9:0]        program_x,
    output logic [9:0]        program_y,
    output logic [15:0]       program_data,
    output logic              busy,
    output logic              frame_overrun
);
    localparam int PW = $clog2(CMD_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] FETCH = 2'd2;
    localparam logic [1:0] RUN   = 2'd3;

    typedef struct packed {
        logic [9:0]        x;
        logic [9:0]        y;
        logic [5:0]        w;
        logic [5:0]        h;
        logic [ROM_AW-1:0] base;
    } cmd_t;

    cmd_t          fifo_mem [CMD_DEPTH];
    cmd_t          head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    logic [1:0]    state;
    logic [9:0]    x0, y0;
    logic [5:0]    w, h, i, j;
    logic [15:0]   hold_data, cur_data;
    logic          hold_vld, pix_vld;
    logic [10:0]   px, py;
    logic          keep, resolve, last_px;

    assign head      = fifo_mem[rd_ptr];
    assign pop       = (state == LOAD);
    assign cmd_ready = (count != CW'(CMD_DEPTH)) || pop;
    assign push      = cmd_valid && cmd_ready && !frame_start;
    assign busy      = (count != '0) || (state != IDLE) || pix_vld;

    // rom_addr runs one word ahead of the pixel being resolved; when the pixel
    // register stalls, the current word is parked in hold_data.
    assign cur_data = hold_vld ? hold_data : rom_data;
    assign px       = {1'b0, x0} + {5'b0, i};
    assign py       = {1'b0, y0} + {5'b0, j};
    assign keep     = (cur_data != TRANSPARENT) && (px < 11'(H_RES)) && (py < 11'(V_RES));
    assign resolve  = (state == RUN) && (!pix_vld || write_strobe);
    assign last_px  = (i == w - 6'd1) && (j == h - 6'd1);

    always_ff @(posedge sram_clk) begin
        if (push) fifo_mem[wr_ptr] <= '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, base: cmd_base};
    end

    always_ff @(posedge sram_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (frame_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sram_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            x0        <= '0;
            y0        <= '0;
            w         <= '0;
            h         <= '0;
            i         <= '0;
            j         <= '0;
            rom_addr  <= '0;
            hold_data <= '0;
            hold_vld  <= 1'b0;
        end else if (frame_start) begin
            state    <= IDLE;
            hold_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: if (count != '0) state <= LOAD;
                LOAD: begin
                    x0       <= head.x;
                    y0       <= head.y;
                    w        <= head.w;
                    h        <= head.h;
                    i        <= '0;
                    j        <= '0;
                    rom_addr <= head.base;
                    state    <= (head.w == '0 || head.h == '0) ? IDLE : FETCH;
                end
                FETCH: begin
                    rom_addr <= rom_addr + ROM_AW'(1);
                    hold_vld <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    if (resolve) begin
                        hold_vld <= 1'b0;
                        if (last_px) begin
                            state <= IDLE;
                        end else begin
                            rom_addr <= rom_addr + ROM_AW'(1);
                            if (i == w - 6'd1) begin
                                i <= '0;
                                j <= j + 6'd1;
                            end else begin
                                i <= i + 6'd1;
                            end
                        end
                    end else if (!hold_vld) begin
                        hold_data <= rom_data;
                        hold_vld  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Invalid pixel register always shows the off-screen park coordinate.
    always_ff @(posedge sram_clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_vld       <= 1'b0;
            program_x     <= 10'd1023;
            program_y     <= 10'd511;
            program_data  <= TRANSPARENT;
            frame_overrun <= 1'b0;
        end else begin
            frame_overrun <= frame_start && busy;
            if (frame_start || (!(resolve && keep) && write_strobe)) begin
                pix_vld      <= 1'b0;
                program_x    <= 10'd1023;
                program_y    <= 10'd511;
                program_data <= TRANSPARENT;
            end else if (resolve && keep) begin
                pix_vld      <= 1'b1;
                program_x    <= px[9:0];
                program_y    <= py[9:0];
                program_data <= cur_data;
            end
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: table of sprite cases plus FIFO-full,
// frame_start and mid-sprite reset sequences.
module tb_sprite_blitter;
    logic        sram_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x = '0, cmd_y = '0;
    logic [5:0]  cmd_w = '0, cmd_h = '0;
    logic [13:0] cmd_base = '0;
    logic [13:0] rom_addr;
    logic [15:0] rom_data;
    logic        write_strobe = 1'b0;
    logic [9:0]  program_x, program_y;
    logic [15:0] program_data;
    logic        busy, frame_overrun;

    sprite_blitter dut (
        .sram_clk(sram_clk), .reset_n(reset_n), .frame_start(frame_start),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_base(cmd_base), .rom_addr(rom_addr),
        .rom_data(rom_data), .write_strobe(write_strobe), .program_x(program_x),
        .program_y(program_y), .program_data(program_data), .busy(busy),
        .frame_overrun(frame_overrun)
    );

    always #5 sram_clk = ~sram_clk;

    logic [15:0] rom [16384];
    always @(posedge sram_clk) rom_data <= rom[rom_addr];

    localparam logic [35:0] PARK = {10'd1023, 10'd511, 16'h0000};

    int n_checks = 0;
    int n_pass = 0;
    logic [35:0] wlog [$];
    int unstable;
    bit have_last = 0, last_ws, last_park;
    logic [35:0] last_pix;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Logs what the controller writes on this strobe, then advances one cycle.
    task automatic tick();
        logic [35:0] cur;
        bit is_park;
        cur = {program_x, program_y, program_data};
        is_park = (program_x == 10'd1023) && (program_y == 10'd511);
        if (write_strobe && !is_park) wlog.push_back(cur);
        if (have_last && !last_ws && !last_park && cur != last_pix) unstable++;
        have_last = 1;
        last_ws = write_strobe;
        last_park = is_park;
        last_pix = cur;
        @(posedge sram_clk);
        @(negedge sram_clk);
    endtask

    task automatic push(input logic [9:0] x, input logic [9:0] y, input logic [5:0] w,
                        input logic [5:0] h, input logic [13:0] base, output bit acc);
        cmd_valid = 1'b1;
        cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_base = base;
        acc = cmd_ready;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int period, output bit timed_out);
        timed_out = 1;
        for (int c = 0; c < 400; c++) begin
            write_strobe = (period != 0) && (c % period == 0);
            tick();
            if (!busy) begin
                timed_out = 0;
                break;
            end
        end
        write_strobe = 1'b0;
    endtask

    typedef struct {
        logic [9:0]        x, y;
        logic [5:0]        w, h;
        logic [13:0]       base;
        logic [7:0][15:0]  words;
        int                period;
        int                nexp;
        logic [3:0][35:0]  exp;
        logic [13:0]       end_addr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit acc, to;
        logic [35:0] got;
        int bad;

        // words are listed high index first: words[0] sits at base
        vecs[0] = '{x: 10'd100, y: 10'd50, w: 6'd2, h: 6'd2, base: 14'h010,
                    words: {64'h0, 16'hA4, 16'hA3, 16'hA2, 16'hA1}, period: 2, nexp: 4,
                    exp: {{10'd101, 10'd51, 16'hA4}, {10'd100, 10'd51, 16'hA3},
                          {10'd101, 10'd50, 16'hA2}, {10'd100, 10'd50, 16'hA1}},
                    end_addr: 14'h014};
        vecs[1] = '{x: 10'd100, y: 10'd50, w: 6'd2, h: 6'd2, base: 14'h010,
                    words: {64'h0, 16'hA4, 16'hA3, 16'h0000, 16'hA1}, period: 2, nexp: 3,
                    exp: {36'h0, {10'd101, 10'd51, 16'hA4},
                          {10'd100, 10'd51, 16'hA3}, {10'd100, 10'd50, 16'hA1}},
                    end_addr: 14'h014};
        vecs[2] = '{x: 10'd638, y: 10'd479, w: 6'd4, h: 6'd2, base: 14'h020,
                    words: {16'hB007, 16'hB006, 16'hB005, 16'hB004,
                            16'hB003, 16'hB002, 16'hB001, 16'hB000}, period: 2, nexp: 2,
                    exp: {72'h0, {10'd639, 10'd479, 16'hB001}, {10'd638, 10'd479, 16'hB000}},
                    end_addr: 14'h028};
        vecs[3] = '{x: 10'd5, y: 10'd7, w: 6'd3, h: 6'd1, base: 14'h040,
                    words: {80'h0, 16'hC3, 16'hC2, 16'hC1}, period: 1, nexp: 3,
                    exp: {36'h0, {10'd7, 10'd7, 16'hC3}, {10'd6, 10'd7, 16'hC2},
                          {10'd5, 10'd7, 16'hC1}},
                    end_addr: 14'h043};
        vecs[4] = '{x: 10'd1023, y: 10'd0, w: 6'd2, h: 6'd1, base: 14'h050,
                    words: {96'h0, 16'hD2, 16'hD1}, period: 1, nexp: 0,
                    exp: {144'h0}, end_addr: 14'h052};
        vecs[5] = '{x: 10'd639, y: 10'd477, w: 6'd1, h: 6'd3, base: 14'h060,
                    words: {80'h0, 16'hE3, 16'hE2, 16'hE1}, period: 3, nexp: 3,
                    exp: {36'h0, {10'd639, 10'd479, 16'hE3}, {10'd639, 10'd478, 16'hE2},
                          {10'd639, 10'd477, 16'hE1}},
                    end_addr: 14'h063};

        for (int a = 0; a < 16384; a++) rom[a] = 16'h0000;

        // reset state
        tick();
        tick();
        check("rst_park", {program_x, program_y, program_data}, PARK);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_overrun", frame_overrun, 0);
        check("rst_rom_addr", rom_addr, 0);
        reset_n = 1'b1;
        tick();

        // idle with strobes: stays parked, never busy
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            write_strobe = (c % 2 == 0);
            tick();
            if ({program_x, program_y, program_data} != PARK || busy) bad++;
        end
        write_strobe = 1'b0;
        check("idle_parked", bad, 0);
        check("idle_no_writes", wlog.size(), 0);

        // table-driven sprite cases
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 8; k++) rom[vecs[v].base + 14'(k)] = vecs[v].words[k];
            wlog.delete();
            unstable = 0;
            push(vecs[v].x, vecs[v].y, vecs[v].w, vecs[v].h, vecs[v].base, acc);
            check($sformatf("v%0d_accept", v), acc, 1);
            drain(vecs[v].period, to);
            check($sformatf("v%0d_timeout", v), to, 0);
            check($sformatf("v%0d_nwrites", v), wlog.size(), vecs[v].nexp);
            for (int k = 0; k < vecs[v].nexp; k++) begin
                got = (k < wlog.size()) ? wlog[k] : 36'hF_FFFF_FFFF;
                check($sformatf("v%0d_write%0d", v, k), got, vecs[v].exp[k]);
            end
            check($sformatf("v%0d_hold_stable", v), unstable, 0);
            check($sformatf("v%0d_park_after", v), {program_x, program_y, program_data}, PARK);
            check($sformatf("v%0d_rom_addr_end", v), rom_addr, vecs[v].end_addr);
        end

        // FIFO full: first sprite stalls on a pending pixel, then 9 pushes of w=0
        rom[14'h070] = 16'h7001;
        rom[14'h071] = 16'h7002;
        wlog.delete();
        unstable = 0;
        push(10'd0, 10'd0, 6'd2, 6'd1, 14'h070, acc);
        for (int c = 0; c < 6; c++) tick();
        for (int k = 0; k < 9; k++) begin
            push(10'd300, 10'd300, 6'd0, 6'd1, 14'h100, acc);
            check($sformatf("fifo_ready%0d", k), acc, (k < 8) ? 1 : 0);
        end
        check("fifo_busy", busy, 1);
        drain(1, to);
        check("fifo_timeout", to, 0);
        check("fifo_nwrites", wlog.size(), 2);
        got = (wlog.size() > 0) ? wlog[0] : 36'hF_FFFF_FFFF;
        check("fifo_write0", got, {10'd0, 10'd0, 16'h7001});
        got = (wlog.size() > 1) ? wlog[1] : 36'hF_FFFF_FFFF;
        check("fifo_write1", got, {10'd1, 10'd0, 16'h7002});
        check("fifo_hold_stable", unstable, 0);

        // frame_start mid-sprite with 3 queued commands plus a simultaneous push
        for (int k = 0; k < 16; k++) rom[14'h080 + 14'(k)] = 16'hF000 + 16'(k);
        push(10'd10, 10'd10, 6'd4, 6'd4, 14'h080, acc);
        push(10'd20, 10'd20, 6'd2, 6'd2, 14'h080, acc);
        push(10'd30, 10'd30, 6'd2, 6'd2, 14'h080, acc);
        push(10'd40, 10'd40, 6'd2, 6'd2, 14'h080, acc);
        for (int c = 0; c < 6; c++) begin
            write_strobe = (c % 2 == 0);
            tick();
        end
        write_strobe = 1'b0;
        check("fs_busy_before", busy, 1);
        frame_start = 1'b1;
        cmd_valid = 1'b1;
        cmd_x = 10'd50; cmd_y = 10'd50; cmd_w = 6'd1; cmd_h = 6'd1; cmd_base = 14'h080;
        tick();
        frame_start = 1'b0;
        cmd_valid = 1'b0;
        check("fs_park", {program_x, program_y, program_data}, PARK);
        check("fs_busy_after", busy, 0);
        check("fs_overrun_pulse", frame_overrun, 1);
        tick();
        check("fs_overrun_one_cycle", frame_overrun, 0);
        wlog.delete();
        for (int c = 0; c < 40; c++) begin
            write_strobe = (c % 2 == 0);
            tick();
        end
        write_strobe = 1'b0;
        check("fs_no_writes", wlog.size(), 0);
        check("fs_still_idle", busy, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("fs_idle_no_overrun", frame_overrun, 0);

        // reset mid-sprite
        push(10'd10, 10'd10, 6'd4, 6'd4, 14'h080, acc);
        for (int c = 0; c < 6; c++) tick();
        check("mr_busy_before", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mr_park", {program_x, program_y, program_data}, PARK);
        check("mr_busy", busy, 0);
        check("mr_rom_addr", rom_addr, 0);
        check("mr_ready", cmd_ready, 1);
        tick();
        reset_n = 1'b1;
        wlog.delete();
        for (int c = 0; c < 20; c++) begin
            write_strobe = 1'b1;
            tick();
        end
        write_strobe = 1'b0;
        check("mr_no_writes", wlog.size(), 0);
        check("mr_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Upstream pixel producer for the double-buffered SRAM frame controller.
- Pops sprite draw commands from an internal FIFO and walks each sprite's pixels in row-major order, fetching colours from a synchronous sprite ROM.
- Drops transparent and off-screen pixels; presents each surviving pixel on program_x/program_y/program_data.
- Holds each pixel until the controller consumes it in a program-write slot.
- Parks on an off-screen coordinate whenever it has nothing to write.

Parameters:
- CMD_DEPTH, 8, command FIFO entries (power of 2).
- ROM_AW, 14, sprite ROM address width.
- TRANSPARENT, 16'h0000, colour key; pixels of this colour are never written.
- H_RES, 640, visible width; x ≥ H_RES is clipped.
- V_RES, 480, visible height; y ≥ V_RES is clipped.

Ports:
- sram_clk  in  1  100 MHz clock; sole clock.
- reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse (sram_clk domain) at each frame-buffer swap.
- cmd_valid  in  1  command push request.
- cmd_ready  out  1  FIFO not full.
- cmd_x  in  10  sprite top-left x.
- cmd_y  in  10  sprite top-left y.
- cmd_w  in  6  sprite width, 1..63.
- cmd_h  in  6  sprite height, 1..63.
- cmd_base  in  ROM_AW  ROM address of the sprite's first pixel.
- rom_addr  out  ROM_AW  sprite ROM address, registered.
- rom_data  in  16  ROM word, valid one cycle after rom_addr changes.
- write_strobe  in  1  high in the cycle the controller samples program_* (write slot).
- program_x  out  10  pixel x.
- program_y  out  10  pixel y.
- program_data  out  16  pixel colour.
- busy  out  1  FIFO non-empty, sprite in progress, or pixel pending.
- frame_overrun  out  1  one-cycle pulse: frame_start arrived while busy.

Behaviour:
- Reset values (async, reset_n=0):
  - FIFO empty; FSM in IDLE; pixel register invalid.
  - cmd_ready=1, busy=0, frame_overrun=0, rom_addr=0.
  - program_x=10'd1023, program_y=10'd511, program_data=TRANSPARENT.
- Push: a command enters the FIFO when cmd_valid && cmd_ready. cmd_ready=0 when CMD_DEPTH entries are held. A push in the same cycle as a pop is accepted when full.
- FSM states:
  - IDLE: if FIFO non-empty, go to LOAD.
  - LOAD: pop head; latch x0, y0, w, h, addr=cmd_base; set i=0, j=0.
    - If w==0 or h==0, discard the command and return to IDLE. No writes result.
    - Otherwise go to FETCH.
  - FETCH: drive rom_addr=addr; next cycle go to RUN.
  - RUN: one sprite pixel is resolved per cycle in which the pixel register is free (invalid, or write_strobe this cycle).
    - On resolve:
      - px = x0+i and py = y0+j, computed at 11 bits.
      - Keep the pixel iff rom_data != TRANSPARENT, px < H_RES and py < V_RES.
      - If kept, load the pixel register with {px[9:0], py[9:0], rom_data} and mark it valid.
    - Then advance: addr+1; i+1; at i==w-1, i=0 and j+1. rom_addr follows addr in the same cycle, so sustained rate is 1 pixel/cycle.
    - After the last pixel (i==w-1, j==h-1) is resolved, go to IDLE. A queued command may start in the next cycle.
- Pixel register:
  - While valid, program_* hold stable until write_strobe.
  - On write_strobe with no new pixel loaded, the register goes invalid and program_* return to the park value (1023, 511, TRANSPARENT). The controller writes unconditionally, so the park coordinate is off-screen by construction.
- Throughput: while any kept pixel is pending, exactly one pixel is consumed per write_strobe. Transparent and clipped pixels consume no slot.
- frame_start has highest priority:
  - Flush the FIFO, abort the current sprite, invalidate the pixel register (park outputs next cycle), and go to IDLE.
  - A simultaneous cmd push is dropped.
  - frame_overrun pulses the following cycle iff busy was 1 in the frame_start cycle.
- Reset asserted mid-sprite: all state returns to reset values immediately. No partial pixel is held.
- busy is combinational from FIFO count, FSM state != IDLE, and pixel valid.

Test Plan:
- After reset, with no commands and write_strobe every 2nd cycle: program_* stay at (1023, 511, 16'h0000) and busy=0.
- Push 1 command (x=100, y=50, w=2, h=2, base=0x10), ROM 0x10..0x13 = A1,A2,A3,A4, strobe every 2nd cycle: the writes are exactly (100,50,A1), (101,50,A2), (100,51,A3), (101,51,A4) in order, each held until its strobe; then park and busy=0.
- Same command with ROM 0x11 = 0x0000: only 3 writes are produced; (101,50) is never written.
- Clip case (x=638, y=479, w=4, h=2): only (638,479) and (639,479) are written; rom_addr still advances through all 8 words.
- Push 9 commands back-to-back with CMD_DEPTH=8 and no strobes: cmd_ready drops after the 8th accepted push (the 9th is not accepted while cmd_ready=0); w=0 commands produce no writes.
- frame_start mid-sprite with 3 commands queued: the next cycle shows park outputs, busy=0 and a one-cycle frame_overrun pulse; the queued commands are never drawn. A frame_start while idle gives no pulse.
